// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential unsigned divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_diff;

    always_comb begin
        r_shift = {r_in, bit_in};
        r_diff  = r_shift - {1'b0, divisor};
        if (r_shift >= {1'b0, divisor}) begin
            // r_in < divisor, so the difference always fits back into WIDTH bits
            r_out = r_diff[WIDTH-1:0];
            q_bit = 1'b1;
        end else begin
            r_out = r_shift[WIDTH-1:0];
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/divider_unsigned4_seq.sv
// Sequential unsigned divider: one restoring step per cycle with a start/busy/done handshake.
module divider_unsigned4_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic             step_q;

    // Dividend is shifted left each step, so its MSB is always the next bit to bring down.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in    (rem_q),
        .bit_in  (dividend_q[WIDTH-1]),
        .divisor (divisor_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (b == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = a;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d    = RUN;
                        dividend_d = a;
                        divisor_d  = b;
                        rem_d      = '0;
                        quo_d      = '0;
                        cnt_d      = '0;
                    end
                end
            end
            RUN: begin
                dividend_d = dividend_q << 1;
                rem_d      = step_r;
                quo_d      = {quo_q[WIDTH-2:0], step_q};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d     = DONE;
                    quotient_d  = {quo_q[WIDTH-2:0], step_q};
                    remainder_d = step_r;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_unsigned4_seq.sv
// Randomized and directed bench for divider_unsigned4_seq against an arithmetic reference model.
module tb_divider_unsigned4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_unsigned4_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, all-ones quotient and dividend as remainder on b==0.
    function automatic void model(input int ua, input int ub, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic dbz);
        if (ub == 0) begin
            q   = W'((1 << W) - 1);
            r   = W'(ua);
            dbz = 1'b1;
        end else begin
            q   = W'(ua / ub);
            r   = W'(ua % ub);
            dbz = 1'b0;
        end
    endfunction

    // Issue one start pulse and wait (bounded) for done; lat counts edges from the accepting one.
    task automatic run_div(input int ua, input int ub, output int lat, output int nbusy,
                           output bit changed);
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        q0      = quotient;
        r0      = remainder;
        changed = 1'b0;
        nbusy   = 0;
        a       = W'(ua);
        b       = W'(ub);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            if (quotient !== q0 || remainder !== r0) changed = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, nbusy;
        bit changed;
        run_div(13, 4, lat, nbusy, changed);
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL basic_latency: got %0d required 5", lat);
        end
        checks++;
        if (nbusy !== 4) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d required 4", nbusy);
        end
        checks++;
        if (quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b required q=3 r=1 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        checks++;
        if (changed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_stable: changed=%b busy_at_done=%b required 0 0", changed, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_div_zero();
        int lat, nbusy;
        bit changed;
        run_div(7, 0, lat, nbusy, changed);
        checks++;
        if (lat !== 1 || nbusy !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dbz_timing: lat=%0d busy_cycles=%0d busy=%b required 1 0 0",
                     lat, nbusy, busy);
        end
        checks++;
        if (quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%0d r=%0d dbz=%b required q=15 r=7 dbz=1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_boundaries();
        int ta[3] = '{3, 15, 0};
        int tb[3] = '{9, 1, 5};
        int lat, nbusy;
        bit changed;
        logic [W-1:0] eq, er;
        logic edbz;
        for (int i = 0; i < 3; i++) begin
            run_div(ta[i], tb[i], lat, nbusy, changed);
            model(ta[i], tb[i], eq, er, edbz);
            checks++;
            if (lat !== 5 || quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
                errors++;
                $display("FAIL boundary %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required 5 %0d %0d %b",
                         ta[i], tb[i], lat, quotient, remainder, div_by_zero, eq, er, edbz);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        a     = 4'd10;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        a   = 4'd15;
        b   = 4'd1;
        lat = 1;
        repeat (2) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 5 || quotient !== 4'd3 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d required 5 3 1",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nbusy;
        bit changed;
        run_div(9, 2, lat, nbusy, changed);
        checks++;
        if (lat !== 5 || quotient !== 4'd4 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required 5 4 1", lat, quotient, remainder);
        end
        // start raised while done is high must be accepted at the very next edge
        a     = 4'd14;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: busy=%b required 1", busy);
        end
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 5 || quotient !== 4'd4 || remainder !== 4'd2) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d required 5 4 2", lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nbusy;
        bit changed;
        a     = 4'd13;
        b     = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d dbz=%b required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: busy=%b done=%b required 0 0", busy, done);
        end
        run_div(11, 3, lat, nbusy, changed);
        checks++;
        if (lat !== 5 || quotient !== 4'd3 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: lat=%0d q=%0d r=%0d dbz=%b required 5 3 2 0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random();
        int ua, ub, lat, nbusy;
        bit changed;
        logic [W-1:0] eq, er;
        logic edbz;
        for (int i = 0; i < 40; i++) begin
            ua = int'($urandom_range(15));
            ub = int'($urandom_range(15));
            run_div(ua, ub, lat, nbusy, changed);
            model(ua, ub, eq, er, edbz);
            checks++;
            if (lat !== ((ub == 0) ? 1 : 5) || quotient !== eq || remainder !== er
                || div_by_zero !== edbz) begin
                errors++;
                $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         ua, ub, lat, quotient, remainder, div_by_zero, eq, er, edbz);
            end
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        int lat, nbusy;
        bit changed;
        logic [W-1:0] eq, er;
        logic edbz;
        for (int ua = 0; ua < 16; ua++) begin
            for (int ub = 0; ub < 16; ub++) begin
                run_div(ua, ub, lat, nbusy, changed);
                model(ua, ub, eq, er, edbz);
                checks++;
                if (lat !== ((ub == 0) ? 1 : 5) || quotient !== eq || remainder !== er
                    || div_by_zero !== edbz) begin
                    errors++;
                    $display("FAIL exhaustive %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                             ua, ub, lat, quotient, remainder, div_by_zero, eq, er, edbz);
                end
                if (ub != 0) begin
                    checks++;
                    if (int'(quotient) * ub + int'(remainder) != ua || int'(remainder) >= ub) begin
                        errors++;
                        $display("FAIL identity %0d/%0d: q=%0d r=%0d violate q*b+r==a, r<b",
                                 ua, ub, quotient, remainder);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
